// File: rtl/des_round_engine.sv
// Iterative DES data path: IP, 16 Feistel rounds (one per clock), FP; round key supplied externally via rk_sel/rk_in.
// Optional abort input enabled by defining DES_ABORT_EN.
module des_round_engine #(
  parameter int unsigned NROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] data_in,
  output logic [3:0]  rk_sel,
  input  logic [47:0] rk_in,
`ifdef DES_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic [63:0] data_out
);

  localparam logic [3:0] LAST = 4'(NROUNDS - 1);

  localparam byte unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam byte unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam byte unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam byte unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each S-box: 64 nibbles, entry {row,col} stored MSB-first.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] f_func(input logic [31:0] r_in, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  b;
    logic [5:0]  idx;
    x = '0;
    for (int i = 0; i < 48; i++) x[6'(47 - i)] = r_in[5'(32 - E_T[6'(i)])];
    x = x ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      b   = x[6'(47 - 6 * i) -: 6];
      idx = {b[5], b[0], b[4:1]};
      s[5'(31 - 4 * i) -: 4] = SBOX[3'(i)][{~idx, 2'b11} -: 4];
    end
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[5'(i)])];
    return y;
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        dec;
  logic [31:0] l;
  logic [31:0] r;

  assign busy = (state == ROUND);

  // Key index follows the latched direction; decrypt walks the schedule backwards.
  always_comb begin
    rk_sel = 4'd0;
    if (state == ROUND) rk_sel = dec ? (4'd15 - cnt) : cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      dec      <= 1'b0;
      l        <= 32'd0;
      r        <= 32'd0;
      data_out <= 64'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dec    <= decrypt;
            {l, r} <= ip_perm(data_in);
            cnt    <= 4'd0;
            state  <= ROUND;
          end
        end
        ROUND: begin
`ifdef DES_ABORT_EN
          if (abort) begin
            l     <= 32'd0;
            r     <= 32'd0;
            cnt   <= 4'd0;
            state <= IDLE;
          end else
`endif
          begin
            l   <= r;
            r   <= l ^ f_func(r, rk_in);
            cnt <= cnt + 4'd1;
            if (cnt == LAST) state <= DONE;
          end
        end
        DONE: begin
          data_out <= fp_perm({r, l});
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine; models the key generator from a 64-bit key.
module tb_des_round_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [63:0] data_in;
  logic [3:0]  rk_sel;
  logic [47:0] rk_in;
  logic        busy;
  logic        done;
  logic [63:0] data_out;
`ifdef DES_ABORT_EN
  logic        abort;
`endif

  int checks = 0;
  int errors = 0;

  logic [47:0] rk_tab [16];
  assign rk_in = rk_tab[rk_sel];

  des_round_engine #(.NROUNDS(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .decrypt(decrypt),
    .data_in(data_in),
    .rk_sel(rk_sel),
    .rk_in(rk_in),
`ifdef DES_ABORT_EN
    .abort(abort),
`endif
    .busy(busy),
    .done(done),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Key generator model: fills the 16 round keys (index N-1 = round N).
  task automatic set_key(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < SH[n]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) rk_tab[n][47 - j] = cd[56 - PC2[j]];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (data_out !== 64'd0) begin errors++; $display("FAIL reset_data_out got %h expected 0", data_out); end
    checks++; if (rk_sel !== 4'd0) begin errors++; $display("FAIL reset_rk_sel got %0d expected 0", rk_sel); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_encrypt();
    int early = 0;
    set_key(64'h133457799BBCDFF1);
    start = 1'b1; decrypt = 1'b0; data_in = 64'h0123456789ABCDEF;
    tick();
    start = 1'b0; decrypt = 1'b1; data_in = '1;  // mid-op changes must be ignored
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL enc_busy got %b expected 1", busy); end
    checks++; if (rk_sel !== 4'd0) begin errors++; $display("FAIL enc_rk_sel0 got %0d expected 0", rk_sel); end
    checks++; if (rk_in !== 48'h1B02EFFC7072) begin errors++; $display("FAIL enc_rk_in0 got %h expected 1b02effc7072", rk_in); end
    for (int k = 1; k < 17; k++) begin
      tick();
      if (done !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL enc_early_done got %0d pulses expected 0", early); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL enc_done got %b expected 1", done); end
    checks++; if (data_out !== 64'h85E813540F0AB405) begin errors++; $display("FAIL enc_data_out got %h expected 85e813540f0ab405", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enc_busy_after got %b expected 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL enc_done_pulse got %b expected 0", done); end
    checks++; if (data_out !== 64'h85E813540F0AB405) begin errors++; $display("FAIL enc_hold got %h expected 85e813540f0ab405", data_out); end
    decrypt = 1'b0;
  endtask

  task automatic test_decrypt();
    int bad = 0;
    start = 1'b1; decrypt = 1'b1; data_in = 64'h85E813540F0AB405;
    tick();
    start = 1'b0; decrypt = 1'b0; data_in = '0;
    checks++; if (rk_sel !== 4'd15) begin errors++; $display("FAIL dec_rk_sel0 got %0d expected 15", rk_sel); end
    checks++; if (rk_in !== 48'hCB3D8B0E17F5) begin errors++; $display("FAIL dec_rk_in0 got %h expected cb3d8b0e17f5", rk_in); end
    for (int k = 0; k < 16; k++) begin
      if (rk_sel !== 4'(15 - k)) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL dec_rk_sel_seq got %0d wrong indices expected 0", bad); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL dec_done got %b expected 1", done); end
    checks++; if (data_out !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL dec_data_out got %h expected 0123456789abcdef", data_out); end
    tick();
  endtask

  task automatic test_vector2();
    set_key(64'h0E329232EA6D0D73);
    start = 1'b1; decrypt = 1'b0; data_in = 64'h8787878787878787;
    tick();
    start = 1'b0;
    repeat (17) tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL v2_done got %b expected 1", done); end
    checks++; if (data_out !== 64'h0000000000000000) begin errors++; $display("FAIL v2_data_out got %h expected 0000000000000000", data_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    int bad_at = 0;
    int bad_busy = 0;
    bit got = 0;
    set_key(64'h133457799BBCDFF1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_idle got %b expected 0", busy); end
    start = 1'b1; decrypt = 1'b0; data_in = 64'h0123456789ABCDEF;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done === 1'b1) begin
        n_done++;
        if (k != 17 && k != 35) bad_at++;
      end
      if ((k == 16 || k == 17) && busy !== 1'b0) bad_busy++;
      if ((k == 0 || k == 18) && busy !== 1'b1) bad_busy++;
      if (k == 35) begin
        checks++; if (data_out !== 64'h85E813540F0AB405) begin errors++; $display("FAIL b2b_data_out got %h expected 85e813540f0ab405", data_out); end
      end
    end
    start = 1'b0;
    checks++; if (n_done != 2) begin errors++; $display("FAIL b2b_count got %0d completions expected 2", n_done); end
    checks++; if (bad_at != 0) begin errors++; $display("FAIL b2b_timing got %0d misplaced done expected 0", bad_at); end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL b2b_busy got %0d wrong samples expected 0", bad_busy); end
    // Third start was accepted at edge 36; let it finish (done after edge 53).
    for (int k = 40; k < 70 && !got; k++) begin
      tick();
      if (done === 1'b1) got = 1;
    end
    checks++; if (!got) begin errors++; $display("FAIL b2b_drain got no done expected done within 30 cycles"); end
    tick();
  endtask

  task automatic test_reset_mid();
    int spurious = 0;
    start = 1'b1; decrypt = 1'b0; data_in = 64'h0123456789ABCDEF;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b expected 0", busy); end
    checks++; if (data_out !== 64'd0) begin errors++; $display("FAIL rstmid_data_out got %h expected 0", data_out); end
    for (int k = 0; k < 20; k++) begin
      if (done !== 1'b0) spurious++;
      tick();
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL rstmid_no_done got %0d pulses expected 0", spurious); end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_redo_done got %b expected 1", done); end
    checks++; if (data_out !== 64'h85E813540F0AB405) begin errors++; $display("FAIL rstmid_redo_data got %h expected 85e813540f0ab405", data_out); end
    tick();
  endtask

`ifdef DES_ABORT_EN
  task automatic test_abort();
    int spurious = 0;
    start = 1'b1; decrypt = 1'b1; data_in = 64'h0123456789ABCDEF;
    tick();
    start = 1'b0;
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", busy); end
    checks++; if (data_out !== 64'h85E813540F0AB405) begin errors++; $display("FAIL abort_data_out got %h expected 85e813540f0ab405", data_out); end
    for (int k = 0; k < 20; k++) begin
      if (done !== 1'b0) spurious++;
      tick();
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses expected 0", spurious); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; data_in = '0;
`ifdef DES_ABORT_EN
    abort = 1'b0;
`endif
    set_key(64'h133457799BBCDFF1);
    test_reset();
    test_encrypt();
    test_decrypt();
    test_vector2();
    test_back_to_back();
    test_reset_mid();
`ifdef DES_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
